// File: rtl/sm_cluster_arbiter.sv
// Purpose: shares one host kernel port, one host response port and one code memory among NUM_SM cores.
// Latency: dispatch 1 cycle after host handshake; response 1 cycle after SM handshake; fetch = 1 issue + memory latency + 1.
// Backpressure: host held off while dispatch slot is occupied; response register stalls SMs while host is not ready.
module sm_cluster_arbiter #(
  parameter int NUM_SM              = 4,
  parameter int DEPTH_WARP          = 3,
  parameter int CODE_ADDR_WIDTH     = 32,
  parameter int CODE_MEM_ADDR_WIDTH = 32,
  parameter int CODE_MEM_DATA_WIDTH = 32,
  localparam int SM_W = (NUM_SM > 1) ? $clog2(NUM_SM) : 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  // host kernel request
  output logic                                  host_req_ready_o,
  input  logic                                  host_req_valid_i,
  input  logic [CODE_ADDR_WIDTH-1:0]            host_req_start_addr_i,
  // host warp-done response
  input  logic                                  host_rsp_ready_i,
  output logic                                  host_rsp_valid_o,
  output logic [DEPTH_WARP-1:0]                 host_rsp_wid_o,
  output logic [SM_W-1:0]                       host_rsp_sm_o,
  // SM kernel dispatch
  output logic [NUM_SM-1:0]                     sm_req_valid_o,
  output logic [CODE_ADDR_WIDTH-1:0]            sm_req_start_addr_o,
  input  logic [NUM_SM-1:0]                     sm_req_ready_i,
  // SM warp-done
  input  logic [NUM_SM-1:0]                     sm_rsp_valid_i,
  input  logic [NUM_SM*DEPTH_WARP-1:0]          sm_rsp_wid_i,
  output logic [NUM_SM-1:0]                     sm_rsp_ready_o,
  // SM code fetch
  input  logic [NUM_SM-1:0]                     sm_code_valid_i,
  input  logic [NUM_SM*CODE_MEM_ADDR_WIDTH-1:0] sm_code_addr_i,
  output logic [NUM_SM-1:0]                     sm_code_ready_o,
  output logic [CODE_MEM_DATA_WIDTH-1:0]        sm_code_data_o,
  // external code memory
  input  logic                                  code_mem_available_i,
  output logic                                  code_read_valid_o,
  output logic [CODE_MEM_ADDR_WIDTH-1:0]        code_read_addr_o,
  input  logic                                  code_read_ready_i,
  input  logic [CODE_MEM_DATA_WIDTH-1:0]        code_read_data_i
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  // Round-robin search starting at ptr; result is {found, index}.
  // Walking offsets high-to-low lets the smallest offset overwrite last.
  function automatic logic [SM_W:0] rr_pick(input logic [NUM_SM-1:0] req,
                                            input logic [SM_W-1:0]   ptr);
    logic [SM_W:0]     res;
    logic [NUM_SM-1:0] sh;
    int                idx;
    res = '0;
    for (int i = NUM_SM - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % NUM_SM;
      sh  = req >> idx;
      if (sh[0]) res = {1'b1, idx[SM_W-1:0]};
    end
    return res;
  endfunction

  // Pointer step with wrap at NUM_SM (which need not be a power of two).
  function automatic logic [SM_W-1:0] inc_ptr(input logic [SM_W-1:0] w);
    if (int'(w) >= NUM_SM - 1) return '0;
    return w + 1'b1;
  endfunction

  function automatic logic [NUM_SM-1:0] onehot(input logic [SM_W-1:0] w);
    return NUM_SM'(1) << w;
  endfunction

  // ---------------------------------------------------------------- dispatch
  logic                       hold_valid;
  logic [CODE_ADDR_WIDTH-1:0] hold_addr;
  logic [SM_W-1:0]            disp_ptr;
  logic [SM_W:0]              disp_pick;
  logic [SM_W-1:0]            disp_idx;
  logic                       disp_fire;
  logic                       host_take;

  assign disp_pick           = rr_pick(sm_req_ready_i, disp_ptr);
  assign disp_idx            = disp_pick[SM_W-1:0];
  assign disp_fire           = hold_valid && disp_pick[SM_W];
  assign sm_req_valid_o      = disp_fire ? onehot(disp_idx) : '0;
  assign sm_req_start_addr_o = hold_addr;
  assign host_req_ready_o    = !hold_valid || disp_fire;
  assign host_take           = host_req_valid_i && host_req_ready_o;

  // Holding register: refilled by the host in the same cycle it drains to an SM.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid <= 1'b0;
      hold_addr  <= '0;
      disp_ptr   <= '0;
    end else begin
      if (host_take) begin
        hold_valid <= 1'b1;
        hold_addr  <= host_req_start_addr_i;
      end else if (disp_fire) begin
        hold_valid <= 1'b0;
      end
      if (disp_fire) disp_ptr <= inc_ptr(disp_idx);
    end
  end

  // ---------------------------------------------------------------- response
  logic                          rsp_valid;
  logic [DEPTH_WARP-1:0]         rsp_wid;
  logic [SM_W-1:0]               rsp_sm;
  logic [SM_W-1:0]               rsp_ptr;
  logic [SM_W:0]                 rsp_pick;
  logic [SM_W-1:0]               rsp_idx;
  logic                          rsp_load;
  logic                          rsp_take;
  logic [NUM_SM*DEPTH_WARP-1:0]  rsp_wid_sh;
  logic [DEPTH_WARP-1:0]         rsp_wid_sel;

  assign rsp_pick         = rr_pick(sm_rsp_valid_i, rsp_ptr);
  assign rsp_idx          = rsp_pick[SM_W-1:0];
  assign rsp_load         = !rsp_valid || host_rsp_ready_i;
  assign rsp_take         = rsp_load && rsp_pick[SM_W];
  assign sm_rsp_ready_o   = rsp_take ? onehot(rsp_idx) : '0;
  assign rsp_wid_sh       = sm_rsp_wid_i >> (int'(rsp_idx) * DEPTH_WARP);
  assign rsp_wid_sel      = rsp_wid_sh[DEPTH_WARP-1:0];
  assign host_rsp_valid_o = rsp_valid;
  assign host_rsp_wid_o   = rsp_wid;
  assign host_rsp_sm_o    = rsp_sm;

  // Output register: only reloads when empty or being consumed, so it stays stable under stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_wid   <= '0;
      rsp_sm    <= '0;
      rsp_ptr   <= '0;
    end else if (rsp_load) begin
      rsp_valid <= rsp_pick[SM_W];
      if (rsp_take) begin
        rsp_wid <= rsp_wid_sel;
        rsp_sm  <= rsp_idx;
        rsp_ptr <= inc_ptr(rsp_idx);
      end
    end
  end

  // -------------------------------------------------------------- code fetch
  logic [1:0]                              state;
  logic [SM_W-1:0]                         owner;
  logic [CODE_MEM_ADDR_WIDTH-1:0]          fetch_addr;
  logic [SM_W-1:0]                         fetch_ptr;
  logic [NUM_SM-1:0]                       code_pulse;
  logic [CODE_MEM_DATA_WIDTH-1:0]          code_data;
  logic [NUM_SM-1:0]                       code_req;
  logic [SM_W:0]                           code_pick;
  logic [SM_W-1:0]                         code_idx;
  logic                                    code_start;
  logic [NUM_SM*CODE_MEM_ADDR_WIDTH-1:0]   code_addr_sh;
  logic [CODE_MEM_ADDR_WIDTH-1:0]          code_addr_sel;

  // An SM being answered this cycle still shows valid; mask it so it is not re-fetched.
  assign code_req          = sm_code_valid_i & ~code_pulse;
  assign code_pick         = rr_pick(code_req, fetch_ptr);
  assign code_idx          = code_pick[SM_W-1:0];
  assign code_start        = (state == ST_IDLE) && code_mem_available_i && code_pick[SM_W];
  assign code_addr_sh      = sm_code_addr_i >> (int'(code_idx) * CODE_MEM_ADDR_WIDTH);
  assign code_addr_sel     = code_addr_sh[CODE_MEM_ADDR_WIDTH-1:0];
  assign code_read_valid_o = (state == ST_ISSUE);
  assign code_read_addr_o  = fetch_addr;
  assign sm_code_ready_o   = code_pulse;
  assign sm_code_data_o    = code_data;

  // Fetch FSM: one read in flight; memory answers are only accepted while waiting.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      owner      <= '0;
      fetch_addr <= '0;
      fetch_ptr  <= '0;
      code_pulse <= '0;
      code_data  <= '0;
    end else begin
      code_pulse <= '0;
      case (state)
        ST_IDLE: begin
          if (code_start) begin
            owner      <= code_idx;
            fetch_addr <= code_addr_sel;
            state      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (code_read_ready_i) begin
            code_data  <= code_read_data_i;
            code_pulse <= onehot(owner);
            fetch_ptr  <= inc_ptr(owner);
            state      <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------- checks
  a_disp_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(sm_req_valid_o));
  a_rsp_onehot:  assert property (@(posedge clk) disable iff (rst) $onehot0(sm_rsp_ready_o));
  a_code_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(sm_code_ready_o));
  a_read_single: assert property (@(posedge clk) disable iff (rst) code_read_valid_o |=> !code_read_valid_o);
  a_rsp_stable:  assert property (@(posedge clk) disable iff (rst)
                   (host_rsp_valid_o && !host_rsp_ready_i) |=>
                   (host_rsp_valid_o && $stable(host_rsp_wid_o) && $stable(host_rsp_sm_o)));

endmodule

// File: tb/tb_sm_cluster_arbiter.sv
// Bench for sm_cluster_arbiter: dispatch vector table plus hand-written response,
// fetch, concurrency and reset sequences, all checked against expectation queues.
module tb_sm_cluster_arbiter;
  localparam int NUM_SM = 4;
  localparam int DW     = 3;
  localparam int AW     = 32;
  localparam int MAW    = 32;
  localparam int MDW    = 32;
  localparam int SM_W   = 2;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    host_req_ready_o;
  logic                    host_req_valid_i;
  logic [AW-1:0]           host_req_start_addr_i;
  logic                    host_rsp_ready_i;
  logic                    host_rsp_valid_o;
  logic [DW-1:0]           host_rsp_wid_o;
  logic [SM_W-1:0]         host_rsp_sm_o;
  logic [NUM_SM-1:0]       sm_req_valid_o;
  logic [AW-1:0]           sm_req_start_addr_o;
  logic [NUM_SM-1:0]       sm_req_ready_i;
  logic [NUM_SM-1:0]       sm_rsp_valid_i;
  logic [NUM_SM*DW-1:0]    sm_rsp_wid_i;
  logic [NUM_SM-1:0]       sm_rsp_ready_o;
  logic [NUM_SM-1:0]       sm_code_valid_i;
  logic [NUM_SM*MAW-1:0]   sm_code_addr_i;
  logic [NUM_SM-1:0]       sm_code_ready_o;
  logic [MDW-1:0]          sm_code_data_o;
  logic                    code_mem_available_i;
  logic                    code_read_valid_o;
  logic [MAW-1:0]          code_read_addr_o;
  logic                    code_read_ready_i;
  logic [MDW-1:0]          code_read_data_i;

  sm_cluster_arbiter #(
    .NUM_SM(NUM_SM), .DEPTH_WARP(DW), .CODE_ADDR_WIDTH(AW),
    .CODE_MEM_ADDR_WIDTH(MAW), .CODE_MEM_DATA_WIDTH(MDW)
  ) dut (
    .clk(clk), .rst(rst),
    .host_req_ready_o(host_req_ready_o), .host_req_valid_i(host_req_valid_i),
    .host_req_start_addr_i(host_req_start_addr_i),
    .host_rsp_ready_i(host_rsp_ready_i), .host_rsp_valid_o(host_rsp_valid_o),
    .host_rsp_wid_o(host_rsp_wid_o), .host_rsp_sm_o(host_rsp_sm_o),
    .sm_req_valid_o(sm_req_valid_o), .sm_req_start_addr_o(sm_req_start_addr_o),
    .sm_req_ready_i(sm_req_ready_i),
    .sm_rsp_valid_i(sm_rsp_valid_i), .sm_rsp_wid_i(sm_rsp_wid_i), .sm_rsp_ready_o(sm_rsp_ready_o),
    .sm_code_valid_i(sm_code_valid_i), .sm_code_addr_i(sm_code_addr_i),
    .sm_code_ready_o(sm_code_ready_o), .sm_code_data_o(sm_code_data_o),
    .code_mem_available_i(code_mem_available_i), .code_read_valid_o(code_read_valid_o),
    .code_read_addr_o(code_read_addr_o), .code_read_ready_i(code_read_ready_i),
    .code_read_data_i(code_read_data_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  typedef struct {
    logic [3:0]  ready;
    logic [31:0] addr;
    logic [3:0]  exp_onehot;
  } dvec_t;

  exp_t        disp_q[$];   // a = onehot, b = start address
  exp_t        rsp_q[$];    // a = sm index, b = wid
  exp_t        rd_q[$];     // a = read address
  exp_t        code_q[$];   // a = onehot, b = data
  dvec_t       dtab[6];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          mem_cnt  = 0;
  logic [31:0] mem_addr = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    if (addr == 32'h40) return 32'hDEAD;
    return addr * 3 + 32'h1234;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every DUT output event against the head of its expectation queue.
  task automatic monitor();
    exp_t e;
    if (sm_req_valid_o != '0) begin
      if (disp_q.size() == 0) check("disp_unexpected", 64'(sm_req_valid_o), 64'h0);
      else begin
        e = disp_q.pop_front();
        check("disp_onehot", 64'(sm_req_valid_o), 64'(e.a));
        check("disp_addr", 64'(sm_req_start_addr_o), 64'(e.b));
      end
    end
    if (host_rsp_valid_o && host_rsp_ready_i) begin
      if (rsp_q.size() == 0) check("rsp_unexpected", 64'(host_rsp_valid_o), 64'h0);
      else begin
        e = rsp_q.pop_front();
        check("rsp_sm", 64'(host_rsp_sm_o), 64'(e.a));
        check("rsp_wid", 64'(host_rsp_wid_o), 64'(e.b));
      end
    end
    if (code_read_valid_o) begin
      if (rd_q.size() == 0) check("read_unexpected", 64'(code_read_valid_o), 64'h0);
      else begin
        e = rd_q.pop_front();
        check("read_addr", 64'(code_read_addr_o), 64'(e.a));
      end
    end
    if (sm_code_ready_o != '0) begin
      if (code_q.size() == 0) check("code_unexpected", 64'(sm_code_ready_o), 64'h0);
      else begin
        e = code_q.pop_front();
        check("code_onehot", 64'(sm_code_ready_o), 64'(e.a));
        check("code_data", 64'(sm_code_data_o), 64'(e.b));
      end
    end
  endtask

  // One cycle: sample on the falling edge, then update host/SM/memory models after the rising edge.
  task automatic tick();
    logic [NUM_SM-1:0] ack_rsp;
    logic [NUM_SM-1:0] ack_code;
    logic              host_acc;
    @(negedge clk);
    monitor();
    ack_rsp  = sm_rsp_ready_o;
    ack_code = sm_code_ready_o;
    host_acc = host_req_valid_i && host_req_ready_o;
    if (code_read_valid_o) begin
      mem_cnt  = 3;
      mem_addr = code_read_addr_o;
    end
    @(posedge clk);
    #1;
    sm_rsp_valid_i  = sm_rsp_valid_i & ~ack_rsp;
    sm_code_valid_i = sm_code_valid_i & ~ack_code;
    if (host_acc) host_req_valid_i = 1'b0;
    code_read_ready_i = 1'b0;
    if (mem_cnt > 0) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        code_read_ready_i = 1'b1;
        code_read_data_i  = mem_word(mem_addr);
      end
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_host_req_ready"}, 64'(host_req_ready_o), 64'h1);
    check({tag, "_sm_req_valid"}, 64'(sm_req_valid_o), 64'h0);
    check({tag, "_sm_req_addr"}, 64'(sm_req_start_addr_o), 64'h0);
    check({tag, "_host_rsp_valid"}, 64'(host_rsp_valid_o), 64'h0);
    check({tag, "_host_rsp_wid"}, 64'(host_rsp_wid_o), 64'h0);
    check({tag, "_host_rsp_sm"}, 64'(host_rsp_sm_o), 64'h0);
    check({tag, "_sm_code_ready"}, 64'(sm_code_ready_o), 64'h0);
    check({tag, "_sm_code_data"}, 64'(sm_code_data_o), 64'h0);
    check({tag, "_read_valid"}, 64'(code_read_valid_o), 64'h0);
    check({tag, "_read_addr"}, 64'(code_read_addr_o), 64'h0);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 60 && (disp_q.size() + rsp_q.size() + rd_q.size() + code_q.size()) != 0; i++)
      tick();
    check({tag, "_disp_left"}, 64'(disp_q.size()), 64'h0);
    check({tag, "_rsp_left"}, 64'(rsp_q.size()), 64'h0);
    check({tag, "_read_left"}, 64'(rd_q.size()), 64'h0);
    check({tag, "_code_left"}, 64'(code_q.size()), 64'h0);
  endtask

  initial begin
    // ready mask, host address, expected one-hot; pointer starts at 0 and carries over
    dtab[0] = '{4'b0100, 32'h100, 4'b0100};
    dtab[1] = '{4'b1111, 32'h104, 4'b1000};
    dtab[2] = '{4'b1010, 32'h108, 4'b0010};
    dtab[3] = '{4'b0011, 32'h10C, 4'b0001};
    dtab[4] = '{4'b0001, 32'h110, 4'b0001};
    dtab[5] = '{4'b1000, 32'h114, 4'b1000};

    rst = 1'b1;
    host_req_valid_i = 1'b0; host_req_start_addr_i = '0; host_rsp_ready_i = 1'b0;
    sm_req_ready_i = '0; sm_rsp_valid_i = '0; sm_rsp_wid_i = '0;
    sm_code_valid_i = '0; sm_code_addr_i = '0; code_mem_available_i = 1'b0;
    code_read_ready_i = 1'b0; code_read_data_i = '0;
    tick();
    tick();
    rst = 1'b0;
    check_idle("reset");

    // Dispatch vectors: one request, dispatched the following cycle.
    for (int i = 0; i < 6; i++) begin
      sm_req_ready_i        = dtab[i].ready;
      host_req_valid_i      = 1'b1;
      host_req_start_addr_i = dtab[i].addr;
      disp_q.push_back('{32'(dtab[i].exp_onehot), dtab[i].addr});
      tick();
      tick();
      check("vec_dispatched", 64'(disp_q.size()), 64'h0);
    end

    // Five back-to-back requests with every SM ready: SM0,1,2,3,0.
    sm_req_ready_i = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      host_req_valid_i      = 1'b1;
      host_req_start_addr_i = 32'h200 + 32'(i);
      disp_q.push_back('{32'(1) << (i % 4), 32'h200 + 32'(i)});
      tick();
    end
    tick();
    check("b2b_dispatch_done", 64'(disp_q.size()), 64'h0);

    // No SM ready: request parks in the holding register and blocks the host.
    sm_req_ready_i        = 4'b0000;
    host_req_valid_i      = 1'b1;
    host_req_start_addr_i = 32'h300;
    tick();
    tick();
    tick();
    check("stall_host_blocked", 64'(host_req_ready_o), 64'h0);
    sm_req_ready_i = 4'b0010;
    disp_q.push_back('{32'b0010, 32'h300});
    tick();
    check("stall_released", 64'(disp_q.size()), 64'h0);
    check("stall_host_ready", 64'(host_req_ready_o), 64'h1);

    // SM1 wid 5 and SM3 wid 2 with the host stalled three cycles.
    sm_req_ready_i         = 4'b0000;
    sm_rsp_wid_i[1*DW +: DW] = 3'd5;
    sm_rsp_wid_i[3*DW +: DW] = 3'd2;
    sm_rsp_valid_i         = 4'b1010;
    rsp_q.push_back('{32'd1, 32'd5});
    rsp_q.push_back('{32'd3, 32'd2});
    tick();
    for (int i = 0; i < 3; i++) begin
      check("hold_rsp_valid", 64'(host_rsp_valid_o), 64'h1);
      check("hold_rsp_wid", 64'(host_rsp_wid_o), 64'd5);
      check("hold_rsp_sm", 64'(host_rsp_sm_o), 64'd1);
      tick();
    end
    host_rsp_ready_i = 1'b1;
    tick();
    tick();
    tick();
    check("rsp_pair_done", 64'(rsp_q.size()), 64'h0);
    check("rsp_empty_after", 64'(host_rsp_valid_o), 64'h0);

    // All four SMs finish at once: one response per cycle.
    for (int k = 0; k < 4; k++) begin
      sm_rsp_wid_i[k*DW +: DW] = 3'(k + 1);
      rsp_q.push_back('{32'(k), 32'(k + 1)});
    end
    sm_rsp_valid_i = 4'b1111;
    for (int i = 0; i < 5; i++) tick();
    check("rsp_full_rate", 64'(rsp_q.size()), 64'h0);

    // SM0 fetches 0x40 and SM2 fetches 0x80; memory answers after three cycles.
    code_mem_available_i       = 1'b1;
    sm_code_addr_i[0*MAW +: MAW] = 32'h40;
    sm_code_addr_i[2*MAW +: MAW] = 32'h80;
    sm_code_valid_i            = 4'b0101;
    rd_q.push_back('{32'h40, 32'h0});
    rd_q.push_back('{32'h80, 32'h0});
    code_q.push_back('{32'b0001, 32'hDEAD});
    code_q.push_back('{32'b0100, mem_word(32'h80)});
    drain("fetch");

    // All three paths active in the same cycle.
    sm_req_ready_i        = 4'b1111;
    host_req_valid_i      = 1'b1;
    host_req_start_addr_i = 32'h500;
    disp_q.push_back('{32'b0100, 32'h500});
    sm_rsp_wid_i[2*DW +: DW] = 3'd6;
    sm_rsp_valid_i        = 4'b0100;
    rsp_q.push_back('{32'd2, 32'd6});
    sm_code_addr_i[1*MAW +: MAW] = 32'h10;
    sm_code_valid_i       = 4'b0010;
    rd_q.push_back('{32'h10, 32'h0});
    code_q.push_back('{32'b0010, mem_word(32'h10)});
    drain("concurrent");

    // Reset while waiting on memory; the late answer must be dropped.
    host_rsp_ready_i           = 1'b0;
    sm_req_ready_i             = 4'b0000;
    sm_code_addr_i[0*MAW +: MAW] = 32'h44;
    sm_code_valid_i            = 4'b0001;
    rd_q.push_back('{32'h44, 32'h0});
    for (int i = 0; i < 20 && rd_q.size() != 0; i++) tick();
    check("rst_read_issued", 64'(rd_q.size()), 64'h0);
    rst                  = 1'b1;
    code_mem_available_i = 1'b0;
    sm_code_valid_i      = 4'b0000;
    tick();
    rst = 1'b0;
    tick();
    tick();
    tick();
    check_idle("after_rst");

    // FSM back in IDLE with pointer 0: a fresh fetch from SM3 completes normally.
    code_mem_available_i         = 1'b1;
    sm_code_addr_i[3*MAW +: MAW] = 32'h7C;
    sm_code_valid_i              = 4'b1000;
    rd_q.push_back('{32'h7C, 32'h0});
    code_q.push_back('{32'b1000, mem_word(32'h7C)});
    drain("post_rst_fetch");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
